// File: rtl/ysyx_25040111_axi_pkg.sv
// Shared AXI definitions for the ysyx_25040111 bus bridges: burst and
// response encodings, the AXI size encoding helper, and the refill FSM
// state type.
package ysyx_25040111_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI arsize/awsize encoding: log2 of the number of bytes per beat
  function automatic logic [2:0] axi_size(input int bytes);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

  typedef enum logic [1:0] {
    REFILL_IDLE = 2'd0,
    REFILL_AR   = 2'd1,
    REFILL_R    = 2'd2
  } refill_state_t;

endpackage

// File: rtl/ysyx_25040111_refill_axi.sv
// I-cache refill to AXI4 read bridge. Each rstart pulse becomes one INCR
// read burst; every returned beat is presented as a one-cycle rok/rdata
// pulse. One burst in flight plus a single pending request slot.
// Optional protocol checker enabled by YSYX_25040111_RRESP_CHK_EN
// (drives the sticky rerr flag; tied low when undefined).
module ysyx_25040111_refill_axi
  import ysyx_25040111_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int ARID_V = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rstart,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [7:0]        rlen,
  output logic              rok,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);

  refill_state_t     state, state_n;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_len;
  logic [7:0]        cnt;
  logic              ar_hs;
  logic              r_hs;

  assign arvalid = (state == REFILL_AR);
  assign rready  = (state == REFILL_R);
  assign arid    = ID_W'(ARID_V);
  assign arsize  = axi_size(DATA_W / 8);
  assign arburst = AXI_BURST_INCR;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= REFILL_IDLE;
    else       state <= state_n;
  end

  // Next-state: the R phase ends only on rlast, whatever the beat count says
  always_comb begin
    state_n = state;
    case (state)
      REFILL_IDLE: if (pend | rstart) state_n = REFILL_AR;
      REFILL_AR:   if (ar_hs) state_n = REFILL_R;
      REFILL_R:    if (r_hs & rlast) state_n = REFILL_IDLE;
      default:     state_n = REFILL_IDLE;
    endcase
  end

  // AR address latch, pending slot, beat counter and returned-beat register
  always_ff @(posedge clock) begin
    if (reset) begin
      araddr    <= '0;
      arlen     <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_len  <= '0;
      cnt       <= '0;
      rok       <= 1'b0;
      rdata     <= '0;
    end else begin
      rok <= 1'b0;
      if (state == REFILL_IDLE) begin
        if (pend) begin
          araddr <= pend_addr;
          arlen  <= pend_len;
          pend   <= rstart;
          if (rstart) begin
            pend_addr <= raddr;
            pend_len  <= rlen;
          end
        end else if (rstart) begin
          araddr <= raddr;
          arlen  <= rlen;
        end
      end else if (rstart && !pend) begin
        pend      <= 1'b1;
        pend_addr <= raddr;
        pend_len  <= rlen;
      end
      if (ar_hs) cnt <= '0;
      if (r_hs) begin
        cnt   <= cnt + 8'd1;
        rdata <= rdata_i;
        rok   <= 1'b1;
      end
    end
  end

`ifdef YSYX_25040111_RRESP_CHK_EN
  logic err_event;

  assign err_event = (r_hs && ((rresp != AXI_RESP_OKAY) ||
                               (rid != ID_W'(ARID_V)) ||
                               (rlast != (cnt == arlen)))) ||
                     (rstart && pend && (state != REFILL_IDLE));

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset)          rerr <= 1'b0;
    else if (err_event) rerr <= 1'b1;
  end
`else
  logic unused_chk;

  assign unused_chk = ^{rresp, rid};
  assign rerr       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25040111_refill_axi.sv
// Self-checking bench for ysyx_25040111_refill_axi. Expected AR requests
// and expected beat data are queued as stimulus is driven and compared
// when the bridge presents them. Honors YSYX_25040111_RRESP_CHK_EN for
// the expected rerr value.
module tb_ysyx_25040111_refill_axi;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rstart = 1'b0;
  logic [31:0] raddr = '0;
  logic [7:0]  rlen = '0;
  logic        rok;
  logic [31:0] rdata;
  logic        rerr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic [3:0]  rid = '0;

  int tests = 0;
  int fails = 0;
  int rokCount = 0;
  int base = 0;

  logic [31:0] expAddr[$];
  logic [7:0]  expLen[$];
  logic [31:0] expData[$];

  ysyx_25040111_refill_axi dut (
    .clock(clock), .reset(reset), .rstart(rstart), .raddr(raddr), .rlen(rlen),
    .rok(rok), .rdata(rdata), .rerr(rerr),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata_i(rdata_i), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor on the falling edge: pops expected beats on rok, checks AR
  // contents while arvalid is up, and records expected data on R handshakes
  always @(negedge clock) begin
    if (rok) begin
      rokCount++;
      if (expData.size() == 0) checkOutput("rok_unexpected", 64'd1, 64'd0);
      else checkOutput("rdata", 64'(rdata), 64'(expData.pop_front()));
    end
    if (arvalid) begin
      if (expAddr.size() == 0) begin
        checkOutput("ar_unexpected", 64'd1, 64'd0);
      end else begin
        checkOutput("araddr", 64'(araddr), 64'(expAddr[0]));
        checkOutput("arlen", 64'(arlen), 64'(expLen[0]));
        if (arready) begin
          checkOutput("arsize", 64'(arsize), 64'd2);
          checkOutput("arburst", 64'(arburst), 64'd1);
          checkOutput("arid", 64'(arid), 64'd0);
          void'(expAddr.pop_front());
          void'(expLen.pop_front());
        end
      end
    end
    if (rvalid && rready) expData.push_back(rdata_i);
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input bit accepted);
    rstart = 1'b1;
    raddr  = addr;
    rlen   = len;
    if (accepted) begin
      expAddr.push_back(addr);
      expLen.push_back(len);
    end
    tick();
    rstart = 1'b0;
  endtask

  task automatic arHandshake(input int delay);
    int n = 0;
    while (!arvalid && n < 50) begin tick(); n++; end
    if (n >= 50) checkOutput("arvalid_timeout", 64'd0, 64'd1);
    repeat (delay) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic waitRready();
    int n = 0;
    while (!rready && n < 50) begin tick(); n++; end
    if (n >= 50) checkOutput("rready_timeout", 64'd0, 64'd1);
  endtask

  task automatic rBeat(input logic [31:0] data, input bit last, input logic [1:0] resp, input int gap);
    repeat (gap) tick();
    waitRready();
    rvalid  = 1'b1;
    rdata_i = data;
    rlast   = last;
    rresp   = resp;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic expectErr(input string tag);
`ifdef YSYX_25040111_RRESP_CHK_EN
    checkOutput(tag, 64'(rerr), 64'd1);
`else
    checkOutput(tag, 64'(rerr), 64'd0);
`endif
  endtask

  task automatic resetDut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    checkOutput({tag, "_rready"}, 64'(rready), 64'd0);
    checkOutput({tag, "_rok"}, 64'(rok), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
    checkOutput({tag, "_rerr"}, 64'(rerr), 64'd0);
    checkOutput({tag, "_araddr"}, 64'(araddr), 64'd0);
    checkOutput({tag, "_arlen"}, 64'(arlen), 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    checkResetState("reset");
    reset = 1'b0;
    tick();

    // 1: single beat
    base = rokCount;
    applyStimulus(32'h8000_0010, 8'd0, 1'b1);
    arHandshake(0);
    rBeat(32'hDEAD_BEEF, 1'b1, 2'b00, 0);
    tick();
    tick();
    checkOutput("t1_rok_count", 64'(rokCount - base), 64'd1);
    checkOutput("t1_rdata_hold", 64'(rdata), 64'hDEAD_BEEF);
    checkOutput("t1_idle", 64'({arvalid, rready}), 64'd0);

    // 2: four-beat burst, stalled AR and gapped R
    base = rokCount;
    applyStimulus(32'h8000_0100, 8'd3, 1'b1);
    arHandshake(3);
    rBeat(32'h1111_0001, 1'b0, 2'b00, 1);
    rBeat(32'h1111_0002, 1'b0, 2'b00, 2);
    rBeat(32'h1111_0003, 1'b0, 2'b00, 0);
    rBeat(32'h1111_0004, 1'b1, 2'b00, 1);
    tick();
    checkOutput("t2_rok_count", 64'(rokCount - base), 64'd4);
    checkOutput("t2_idle", 64'({arvalid, rready}), 64'd0);

    // 3: back-to-back request on the last handshake
    base = rokCount;
    applyStimulus(32'h8000_0200, 8'd1, 1'b1);
    arHandshake(0);
    rBeat(32'h2222_0001, 1'b0, 2'b00, 0);
    waitRready();
    rvalid  = 1'b1;
    rdata_i = 32'h2222_0002;
    rlast   = 1'b1;
    rstart  = 1'b1;
    raddr   = 32'h8000_0300;
    rlen    = 8'd0;
    expAddr.push_back(32'h8000_0300);
    expLen.push_back(8'd0);
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rstart = 1'b0;
    checkOutput("t3_gap_cycle", 64'(arvalid), 64'd0);
    tick();
    checkOutput("t3_arvalid", 64'(arvalid), 64'd1);
    checkOutput("t3_araddr", 64'(araddr), 64'h8000_0300);
    arHandshake(0);
    rBeat(32'h2222_0003, 1'b1, 2'b00, 0);
    tick();
    tick();
    checkOutput("t3_rok_count", 64'(rokCount - base), 64'd3);
    checkOutput("t3_rerr_clean", 64'(rerr), 64'd0);

    // 4: pending-slot overflow during R
    base = rokCount;
    applyStimulus(32'h8000_0400, 8'd1, 1'b1);
    arHandshake(0);
    applyStimulus(32'h8000_0500, 8'd0, 1'b1);
    applyStimulus(32'h8000_0600, 8'd2, 1'b0);
    rBeat(32'h3333_0001, 1'b0, 2'b00, 0);
    rBeat(32'h3333_0002, 1'b1, 2'b00, 1);
    arHandshake(0);
    rBeat(32'h3333_0003, 1'b1, 2'b00, 0);
    tick();
    tick();
    expectErr("t4_rerr");
    repeat (4) tick();
    expectErr("t4_rerr_sticky");
    checkOutput("t4_no_extra_ar", 64'(arvalid), 64'd0);
    checkOutput("t4_rok_count", 64'(rokCount - base), 64'd3);
    resetDut();

    // 5a: SLVERR on beat 2 of 4
    base = rokCount;
    applyStimulus(32'h8000_0700, 8'd3, 1'b1);
    arHandshake(1);
    rBeat(32'h4444_0001, 1'b0, 2'b00, 0);
    rBeat(32'h4444_0002, 1'b0, 2'b10, 1);
    rBeat(32'h4444_0003, 1'b0, 2'b00, 0);
    rBeat(32'h4444_0004, 1'b1, 2'b00, 0);
    tick();
    tick();
    expectErr("t5a_rerr");
    checkOutput("t5a_rok_count", 64'(rokCount - base), 64'd4);
    resetDut();
    checkOutput("t5_rerr_cleared", 64'(rerr), 64'd0);

    // 5b: early rlast on beat 2 of rlen=3
    base = rokCount;
    applyStimulus(32'h8000_0800, 8'd3, 1'b1);
    arHandshake(0);
    rBeat(32'h5555_0001, 1'b0, 2'b00, 0);
    rBeat(32'h5555_0002, 1'b1, 2'b00, 0);
    tick();
    tick();
    checkOutput("t5b_idle", 64'({arvalid, rready}), 64'd0);
    checkOutput("t5b_rok_count", 64'(rokCount - base), 64'd2);
    expectErr("t5b_rerr");
    resetDut();

    // 6: reset after beat 1 of 4, then a fresh request
    base = rokCount;
    applyStimulus(32'h8000_0900, 8'd3, 1'b1);
    arHandshake(0);
    rBeat(32'h6666_0001, 1'b0, 2'b00, 0);
    tick();
    reset = 1'b1;
    tick();
    checkResetState("t6");
    reset = 1'b0;
    applyStimulus(32'h8000_0A00, 8'd0, 1'b1);
    arHandshake(0);
    rBeat(32'h6666_0002, 1'b1, 2'b00, 0);
    tick();
    tick();
    checkOutput("t6_rok_count", 64'(rokCount - base), 64'd2);
    checkOutput("t6_rdata", 64'(rdata), 64'h6666_0002);

    checkOutput("ar_queue_empty", 64'(expAddr.size()), 64'd0);
    checkOutput("data_queue_empty", 64'(expData.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
